mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; the product is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset, asserted at 0.
REQ-004 SHALL have port req_valid, input, 2 bits: per-requester operation request.
REQ-005 SHALL have port req_ready, output, 2 bits: per-requester grant; an operation is accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-006 SHALL have ports a0, b0, a1, b1, inputs, WIDTH bits each: the operands of requester 0 and requester 1.
REQ-007 SHALL have port rsp_valid, output, 2 bits: a one-cycle completion pulse to the owning requester.
REQ-008 SHALL have port product, output, 2*WIDTH bits: the unsigned result of the most recent completed operation.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-011 In IDLE, SHALL assert req_ready only for the single granted requester, selected combinationally from req_valid and a round-robin pointer.
REQ-012 SHALL give the grant to the requester named by the pointer when both are valid, otherwise to the only valid requester.
REQ-013 SHALL hold req_ready at 2'b00 in BUSY and DONE.
REQ-014 On acceptance, SHALL capture the operands of the granted requester and the grant index, load a bit counter with WIDTH, and enter BUSY.
REQ-015 In BUSY, SHALL perform one unsigned shift-add step per cycle, decrement the counter, and enter DONE when the counter reaches 0, so BUSY lasts exactly WIDTH cycles.
REQ-016 In DONE, SHALL register product, pulse rsp_valid[grant] for exactly one cycle, set the pointer to the other requester, and return to IDLE.
REQ-017 Latency: rsp_valid SHALL be high in the cycle beginning WIDTH+1 edges after the accepting edge.
REQ-018 Throughput: one operation per WIDTH+2 cycles at most; no acceptance is possible in the DONE cycle.
REQ-019 product SHALL hold its value between completions and SHALL be unchanged by new requests until the next DONE.
REQ-020 Operand changes after acceptance SHALL have no effect on the result.
REQ-021 Deasserting req_valid before a handshake SHALL be legal and SHALL have no effect.
REQ-022 Arithmetic SHALL be unsigned with no overflow: the maximum result (2^WIDTH-1)^2 SHALL fit in 2*WIDTH bits.

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, busy=0, product=0, counter=0, and pointer=0.
REQ-024 Reset during BUSY or DONE SHALL abort the operation; no rsp_valid SHALL be issued for it after release.
REQ-025 The first grant after reset SHALL favour requester 0.

Configuration
REQ-026 With MULT_ARB_ZERO_SKIP_EN defined, an accepted operation with a zero operand SHALL go directly from IDLE to DONE, giving rsp_valid one cycle after acceptance with product=0.
REQ-027 Without MULT_ARB_ZERO_SKIP_EN, zero operands SHALL take the full WIDTH-cycle BUSY path, and REQ-017 SHALL apply unchanged.

Structure
REQ-028 Package mult_arb_pkg SHALL hold the FSM state encoding (IDLE/BUSY/DONE), the default WIDTH, and the requester count constant (2).
REQ-029 Sub-module mult_engine SHALL contain the shift-add datapath with start/done, and SHALL be instantiated once.
REQ-030 mult_arbiter SHALL own the arbitration, the pointer, and the FSM.

Verification (WIDTH=4)
REQ-031 Requester 0 sends a0=3, b0=2 alone -> req_ready[0] high in the accept cycle, rsp_valid[0] pulses 5 cycles later, product=6.
REQ-032 Both requesters valid after reset, with a0=3, b0=5 and a1=15, b1=15 -> requester 0 is served first with product=15, then requester 1 with product=225; rsp_valid pulses are 6 cycles apart.
REQ-033 Requester 1 is held continuously valid while requester 0 re-requests -> grants alternate 0,1,0,1 with no starvation.
REQ-034 reset is driven to 0 for 1 cycle, 2 cycles into BUSY -> outputs reach reset values immediately, no rsp_valid follows, and a subsequent a0=2, b0=3 returns 6.
REQ-035 a0=0, b0=9 is sent -> with the macro, rsp_valid comes 1 cycle after acceptance with product=0; without the macro, it comes after 5 cycles with product=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the two-requester shift-add multiplier arbiter.
// No logic; latency n/a; backpressure n/a.
// Holds the FSM encoding, default operand width and requester count.
package mult_arb_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int NUM_REQ   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mult_engine.sv
// Unsigned shift-add multiplier datapath, one partial-product step per cycle.
// Latency: WIDTH cycles after start; done is high during the final step cycle.
// Backpressure: none; a start while running restarts the operation.
module mult_engine
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

    // The edge that takes cnt from 1 to 0 applies the last partial product.
    assign done   = (cnt == CW'(1));
    assign result = acc;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter granting two requesters access to one shift-add multiplier.
// Latency: rsp_valid WIDTH+1 edges after accept (1 edge for zero operands with MULT_ARB_ZERO_SKIP_EN).
// Backpressure: req_ready is low outside IDLE; one operation in flight at a time.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic               ptr;
    logic               gnt_q;
    logic               gidx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               skip;
    logic               skip_q;
    logic               eng_done;
    logic [2*WIDTH-1:0] eng_result;

    // Pointer only matters on contention; otherwise the lone requester wins.
    always_comb begin
        gidx   = (req_valid == 2'b11) ? ptr : req_valid[1];
        gnt_oh = (req_valid == '0) ? 2'b00 : (gidx ? 2'b10 : 2'b01);
    end

    assign accept = |(req_valid & req_ready);
    assign sel_a  = gidx ? a1 : a0;
    assign sel_b  = gidx ? b1 : b0;

`ifdef MULT_ARB_ZERO_SKIP_EN
    assign skip = (sel_a == '0) || (sel_b == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)   state_nxt = skip ? ST_DONE : ST_BUSY;
            ST_BUSY: if (eng_done) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE) ? gnt_oh : '0;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q     <= 1'b0;
            skip_q    <= 1'b0;
            ptr       <= 1'b0;
            product   <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                gnt_q  <= gidx;
                skip_q <= skip;
            end
            if (state == ST_DONE) begin
                rsp_valid[gnt_q] <= 1'b1;
                product          <= skip_q ? '0 : eng_result;
                ptr              <= ~gnt_q;
            end
        end
    end

    mult_engine #(.WIDTH(WIDTH)) u_engine (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && !skip),
        .a      (sel_a),
        .b      (sel_b),
        .done   (eng_done),
        .result (eng_result)
    );

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized bench for mult_arbiter against a transaction-level model.
module tb_mult_arbiter;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [1:0]     rsp_valid;
    logic [2*W-1:0] product;
    logic           busy;

    always #5 clk = ~clk;

    mult_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rsp_valid (rsp_valid),
        .product   (product),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: one job in flight, finishing (and freeing the unit) idle_at edges in.
    int             t = 0;
    int             idle_at = 0;
    bit             pend = 0;
    int             pend_idx = 0;
    logic [2*W-1:0] pend_prod = '0;
    logic [2*W-1:0] m_prod = '0;
    logic [1:0]     m_rsp = '0;
    bit             ptr = 0;
    bit             m_acc = 0;
    int             acc_t = 0;

    int             rsp_count = 0;
    int             obs_rsp_t = 0;
    int             obs_rsp_idx = 0;
    logic [2*W-1:0] obs_rsp_prod = '0;
    int             grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_grant();
        if (t < idle_at || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return ptr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    task automatic check_outputs();
        chk("req_ready", {30'd0, req_ready}, {30'd0, model_grant()});
        chk("busy", {31'd0, busy}, {31'd0, (t < idle_at)});
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, m_rsp});
        chk("product", {24'd0, product}, {24'd0, m_prod});
        if ((req_valid & req_ready) != 2'b00) grants.push_back(int'(req_ready[1]));
        if (rsp_valid != 2'b00) begin
            rsp_count++;
            obs_rsp_t    = t;
            obs_rsp_idx  = int'(rsp_valid[1]);
            obs_rsp_prod = product;
        end
    endtask

    task automatic model_edge();
        logic [1:0]     g;
        logic [2*W-1:0] opa, opb;
        int             lat;
        g = model_grant();
        t++;
        m_rsp = 2'b00;
        m_acc = 0;
        if (g != 2'b00) begin
            opa       = g[1] ? {4'd0, a1} : {4'd0, a0};
            opb       = g[1] ? {4'd0, b1} : {4'd0, b0};
            pend      = 1;
            pend_idx  = int'(g[1]);
            pend_prod = opa * opb;
            lat       = W + 1;
`ifdef MULT_ARB_ZERO_SKIP_EN
            if (opa == 0 || opb == 0) lat = 1;
`endif
            idle_at = t + lat;
            m_acc   = 1;
            acc_t   = t;
        end else if (pend && t == idle_at) begin
            m_rsp  = (pend_idx == 1) ? 2'b10 : 2'b01;
            m_prod = pend_prod;
            ptr    = (pend_idx == 0);
            pend   = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_product", {24'd0, product}, 32'd0);
        pend   = 0;
        ptr    = 0;
        m_prod = '0;
        m_rsp  = 2'b00;
        m_acc  = 0;
        @(posedge clk);
        t++;
        idle_at = t;
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_acc(input string tag);
        for (int i = 0; i < 30 && !m_acc; i++) tick();
        if (!m_acc) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int start_cnt;
        start_cnt = rsp_count;
        for (int i = 0; i < 30 && rsp_count == start_cnt; i++) tick();
        if (rsp_count == start_cnt) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (t < idle_at || pend); i++) tick();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1);
    end

    initial begin
        int r0t;
        int rc;
        int exp_lat;
        req_valid = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();
        tick();

        // Single requester 0: 3*2
        req_valid = 2'b01; a0 = 4'd3; b0 = 4'd2;
        wait_acc("acc_single");
        req_valid = 2'b00; a0 = 4'hf; b0 = 4'hf;
        wait_rsp("rsp_single");
        chk("lat_single", obs_rsp_t - acc_t, 32'd5);
        chk("prod_single", {24'd0, obs_rsp_prod}, 32'd6);
        chk("idx_single", obs_rsp_idx, 32'd0);
        drain();

        // Contention right after reset: requester 0 first
        do_reset();
        req_valid = 2'b11; a0 = 4'd3; b0 = 4'd5; a1 = 4'd15; b1 = 4'd15;
        wait_acc("acc_both0");
        req_valid = 2'b10;
        wait_rsp("rsp_both0");
        r0t = obs_rsp_t;
        chk("idx_both0", obs_rsp_idx, 32'd0);
        chk("prod_both0", {24'd0, obs_rsp_prod}, 32'd15);
        wait_acc("acc_both1");
        req_valid = 2'b00;
        wait_rsp("rsp_both1");
        chk("idx_both1", obs_rsp_idx, 32'd1);
        chk("prod_both1", {24'd0, obs_rsp_prod}, 32'd225);
        chk("gap_both", obs_rsp_t - r0t, 32'd6);
        drain();

        // Both held valid: grants must alternate
        grants.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 80 && grants.size() < 4; i++) begin
            a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            tick();
        end
        req_valid = 2'b00;
        chk("rr_count", (grants.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (grants.size() >= 4) begin
            chk("rr_g0", grants[0], 32'd0);
            chk("rr_g1", grants[1], 32'd1);
            chk("rr_g2", grants[2], 32'd0);
            chk("rr_g3", grants[3], 32'd1);
        end
        drain();

        // Reset two cycles into BUSY aborts the job
        req_valid = 2'b01; a0 = 4'd7; b0 = 4'd7;
        wait_acc("acc_abort");
        req_valid = 2'b00;
        tick();
        tick();
        do_reset();
        rc = rsp_count;
        for (int i = 0; i < 8; i++) tick();
        chk("no_rsp_after_abort", rsp_count - rc, 32'd0);
        req_valid = 2'b01; a0 = 4'd2; b0 = 4'd3;
        wait_acc("acc_post_abort");
        req_valid = 2'b00;
        wait_rsp("rsp_post_abort");
        chk("prod_post_abort", {24'd0, obs_rsp_prod}, 32'd6);
        drain();

        // Zero operand
`ifdef MULT_ARB_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 5;
`endif
        req_valid = 2'b01; a0 = 4'd0; b0 = 4'd9;
        wait_acc("acc_zero");
        req_valid = 2'b00; a0 = 4'd5;
        wait_rsp("rsp_zero");
        chk("lat_zero", obs_rsp_t - acc_t, exp_lat);
        chk("prod_zero", {24'd0, obs_rsp_prod}, 32'd0);
        drain();

        // Random traffic, including zeros and operand churn
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            a0 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            b0 = 4'($urandom);
            a1 = 4'($urandom);
            b1 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            tick();
        end
        req_valid = 2'b00;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
